// File: rtl/cpu_pkg.sv
// cpu_pkg: phase encodings, opcode/ALU codes and instruction predicates shared by the sequencer
package cpu_pkg;
   typedef enum logic [2:0] {
      PH_IDLE   = 3'd0,
      PH_FETCH  = 3'd1,
      PH_DECODE = 3'd2,
      PH_EXEC   = 3'd3,
      PH_MEM    = 3'd4,
      PH_WB     = 3'd5
   } phase_t;
   localparam logic [1:0] OP_LD  = 2'b00;
   localparam logic [1:0] OP_ST  = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ALU = 2'b11;
   localparam logic [3:0] ALU_CMP = 4'b0101;
   localparam logic [3:0] ALU_MOV = 4'b0110;
   localparam logic [3:0] ALU_HLT = 4'b1111;
   function automatic logic is_hlt(input logic [1:0] op, input logic [3:0] fn);
      return op == OP_ALU && fn == ALU_HLT;
   endfunction
   function automatic logic is_mem(input logic [1:0] op);
      return op == OP_LD || op == OP_ST;
   endfunction
   // ALU codes 0000-0101 and 1000-1011 update flags; MOV, HLT and the rest leave them alone
   function automatic logic flag_upd(input logic [1:0] op, input logic [3:0] fn);
      return op == OP_ALU && (fn <= ALU_CMP || fn[3:2] == 2'b10);
   endfunction
endpackage

// File: rtl/cpu_flag_reg.sv
// cpu_flag_reg: 4-bit S/Z/C/V flag register with load enable
//  clk, rst (async active-low), load (capture d), d {S,Z,C,V} in, q {S,Z,C,V} out
module cpu_flag_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] d,
   output logic [3:0] q
);
   always_ff @(posedge clk or negedge rst)
      if (!rst) q <= '0;
      else if (load) q <= d;
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: instruction phase FSM, mem_req decode, flag register and retired counter
//  Inputs : clk, rst (async active-low), start, ir[15:0], mem_ack, alu_s/z/c/v
//           step_mode, step (only when SINGLE_STEP_EN is defined)
//  Outputs: phase[2:0], mem_req, S/Z/C/V, running, halted, retired[CNT_W-1:0]
//  SINGLE_STEP_EN: with step_mode=1 the write-back phase waits for step before the next fetch
module phase_sequencer
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      ir,
   input  logic             mem_ack,
   input  logic             alu_s,
   input  logic             alu_z,
   input  logic             alu_c,
   input  logic             alu_v,
`ifdef SINGLE_STEP_EN
   input  logic             step_mode,
   input  logic             step,
`endif
   output logic [2:0]       phase,
   output logic             mem_req,
   output logic             S,
   output logic             Z,
   output logic             C,
   output logic             V,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);
   phase_t     ph, ph_nx;
   logic       hold_wb, retire, halt;
   logic [3:0] flags;
   logic       unused_ir;
   assign unused_ir = ^{ir[13:8], ir[3:0]};
`ifdef SINGLE_STEP_EN
   assign hold_wb = step_mode && !step;
`else
   assign hold_wb = 1'b0;
`endif
   always_comb begin
      ph_nx  = PH_IDLE;
      retire = 1'b0;
      halt   = 1'b0;
      case (ph)
         PH_IDLE:   ph_nx = start ? PH_FETCH : PH_IDLE;
         PH_FETCH:  ph_nx = mem_ack ? PH_DECODE : PH_FETCH;
         PH_DECODE: begin
            halt  = is_hlt(ir[15:14], ir[7:4]);
            ph_nx = halt ? PH_IDLE : PH_EXEC;
         end
         PH_EXEC:   ph_nx = PH_MEM;
         PH_MEM:    ph_nx = (is_mem(ir[15:14]) && !mem_ack) ? PH_MEM : PH_WB;
         PH_WB: begin
            ph_nx  = hold_wb ? PH_WB : PH_FETCH;
            retire = !hold_wb;
         end
         default:   ph_nx = PH_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         ph      <= PH_IDLE;
         halted  <= 1'b0;
         retired <= '0;
      end else begin
         ph <= ph_nx;
         if (ph == PH_IDLE && start) halted <= 1'b0;
         else if (halt) halted <= 1'b1;
         if (retire || halt) retired <= retired + CNT_W'(1);
      end
   cpu_flag_reg u_flags (
      .clk  (clk),
      .rst  (rst),
      .load (ph == PH_EXEC && flag_upd(ir[15:14], ir[7:4])),
      .d    ({alu_s, alu_z, alu_c, alu_v}),
      .q    (flags)
   );
   assign {S, Z, C, V} = flags;
   assign phase   = ph;
   assign mem_req = ph == PH_FETCH || (ph == PH_MEM && is_mem(ir[15:14]));
   assign running = ph != PH_IDLE;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: randomized instruction-level check of phase_sequencer against a phase-list model
module tb_phase_sequencer;
   localparam int CNT_W = 8;
   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [15:0]      ir = '0;
   logic             mem_ack = 1'b0;
   logic             alu_s = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
`ifdef SINGLE_STEP_EN
   logic             step_mode = 1'b0;
   logic             step = 1'b0;
`endif
   logic [2:0]       phase;
   logic             mem_req, S, Z, C, V, running, halted;
   logic [CNT_W-1:0] retired;
   int               n_chk = 0;
   int               n_fail = 0;
   logic [3:0]       ef = '0;
   logic             eh = 1'b0;
   logic [CNT_W-1:0] er = '0;

   phase_sequencer #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .ir(ir), .mem_ack(mem_ack),
      .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
`ifdef SINGLE_STEP_EN
      .step_mode(step_mode), .step(step),
`endif
      .phase(phase), .mem_req(mem_req), .S(S), .Z(Z), .C(C), .V(V),
      .running(running), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_state(input int p);
      chk("phase", 32'(phase), 32'(p));
      chk("mem_req", 32'(mem_req), 32'(p == 1 || (p == 4 && ir[15:14] < 2'd2)));
      chk("running", 32'(running), 32'(p != 0));
      chk("halted", 32'(halted), 32'(eh));
      chk("flags", 32'({S, Z, C, V}), 32'(ef));
      chk("retired", 32'(retired), 32'(er));
   endtask

   task automatic do_start();
      check_state(0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      eh = 1'b0;
      check_state(1);
   endtask

   // Builds the expected per-cycle phase list for one instruction from its class and the
   // chosen wait counts, then plays it against the DUT starting in the fetch phase.
   task automatic run_instr(input logic [15:0] i, input int w1, input int w4, input int w5,
                            input logic [3:0] f);
      int   q[$];
      logic mem, hlt, upd, last;
      int   fn;
      fn  = int'(i[7:4]);
      mem = i[15:14] < 2'd2;
      hlt = i[15:14] == 2'd3 && fn == 15;
      upd = i[15:14] == 2'd3 && (fn <= 5 || (fn >= 8 && fn <= 11));
      ir = i;
      {alu_s, alu_z, alu_c, alu_v} = f;
      repeat (w1 + 1) q.push_back(1);
      q.push_back(2);
      if (hlt) q.push_back(0);
      else begin
         q.push_back(3);
         repeat (mem ? w4 + 1 : 1) q.push_back(4);
         repeat (w5 + 1) q.push_back(5);
         q.push_back(1);
      end
      for (int k = 0; k < q.size(); k++) begin
         check_state(q[k]);
         if (k == q.size() - 1) break;
         last    = q[k + 1] != q[k];
         mem_ack = (q[k] == 1 || (q[k] == 4 && mem)) ? last : 1'($urandom);
         start   = 1'($urandom);
`ifdef SINGLE_STEP_EN
         step = (q[k] == 5) ? last : 1'($urandom);
`endif
         @(posedge clk); #1;
         if (q[k] == 3 && upd) ef = f;
         if ((q[k] == 5 && q[k + 1] == 1) || (q[k] == 2 && q[k + 1] == 0)) er = er + 1'b1;
         if (q[k] == 2 && q[k + 1] == 0) eh = 1'b1;
      end
      mem_ack = 1'b0;
      start   = 1'b0;
`ifdef SINGLE_STEP_EN
      step = 1'b0;
`endif
   endtask

   initial begin
      logic [15:0] i;
      int          w5;
      mem_ack = 1'b1;
      start   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_state(0);
      mem_ack = 1'b0;
      start   = 1'b0;
      rst     = 1'b1;
      @(posedge clk); #1;
      check_state(0);
      do_start();
      run_instr(16'hC000, 0, 0, 0, 4'b1011);
      run_instr(16'h0000, 0, 3, 0, 4'b0000);
      run_instr(16'h4000, 2, 1, 0, 4'b1111);
      run_instr(16'hC060, 0, 0, 0, 4'b0100);
      run_instr(16'hC050, 0, 0, 0, 4'b0100);
      run_instr(16'h8000, 0, 0, 0, 4'b1111);
      run_instr(16'hC0F0, 0, 0, 0, 4'b1111);
      chk("halt_idle", 32'(phase), 32'd0);
      do_start();
`ifdef SINGLE_STEP_EN
      step_mode = 1'b1;
      run_instr(16'hC010, 0, 0, 3, 4'b0110);
      step_mode = 1'b0;
`endif
      for (int n = 0; n < 320; n++) begin
         i = 16'($urandom);
         i[15:14] = 2'($urandom_range(0, 3));
         w5 = 0;
`ifdef SINGLE_STEP_EN
         step_mode = 1'($urandom);
         if (step_mode) w5 = $urandom_range(0, 2);
`endif
         run_instr(i, $urandom_range(0, 2), $urandom_range(0, 2), w5, 4'($urandom));
         if (phase == 3'd0 && eh) do_start();
      end
`ifdef SINGLE_STEP_EN
      step_mode = 1'b0;
`endif
      run_instr(16'hC000, 0, 0, 0, 4'b1111);
      ir = 16'h0000;
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_state(4);
      #2 rst = 1'b0;
      #1;
      ef = '0;
      eh = 1'b0;
      er = '0;
      check_state(0);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      check_state(0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
